// File: rtl/vram_blitter_pkg.sv
// Shared definitions for the VRAM blitter: FSM state encoding, CPU register map,
// video-controller port addresses and CTRL bit positions.
package vram_blitter_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SET_STEP,
        S_SET_RH,
        S_SET_RL,
        S_RD,
        S_RD_WAIT,
        S_SET_WH,
        S_SET_WL,
        S_WR,
        S_FIN
    } state_e;

    localparam logic [3:0] REG_CTRL  = 4'd0;
    localparam logic [3:0] REG_DST_H = 4'd1;
    localparam logic [3:0] REG_DST_L = 4'd2;
    localparam logic [3:0] REG_SRC_H = 4'd3;
    localparam logic [3:0] REG_SRC_L = 4'd4;
    localparam logic [3:0] REG_LEN_H = 4'd5;
    localparam logic [3:0] REG_LEN_L = 4'd6;
    localparam logic [3:0] REG_FILLV = 4'd7;
    localparam logic [3:0] REG_STEP  = 4'd8;

    localparam logic [3:0] VC_DST_H = 4'hA;
    localparam logic [3:0] VC_DST_L = 4'hB;
    localparam logic [3:0] VC_SRC_H = 4'hC;
    localparam logic [3:0] VC_SRC_L = 4'hD;
    localparam logic [3:0] VC_STEP  = 4'hE;
    localparam logic [3:0] VC_DATA  = 4'hF;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_MODE  = 1;
    localparam int unsigned CTRL_ABORT = 2;
    localparam int unsigned CTRL_IE    = 3;

    function automatic logic [7:0] ctrl_status(input logic done, input logic ie,
                                               input logic mode, input logic busy);
        return {done, 3'b000, ie, mode, 1'b0, busy};
    endfunction

endpackage

// File: rtl/vram_blitter_if.sv
// Master-side register port to the video controller.
interface vram_blitter_if;
    logic [3:0] m_ad;
    logic [7:0] m_do;
    logic [7:0] m_di;
    logic       m_rw;
    logic       m_cs;

    modport master (output m_ad, output m_do, output m_rw, output m_cs, input m_di);
    modport slave  (input m_ad, input m_do, input m_rw, input m_cs, output m_di);
endinterface

// File: rtl/vram_blitter_bus_master.sv
// Decodes the blitter FSM state into one video-controller register access per cycle;
// all bus fields are held at zero whenever no access is issued.
module vram_bus_master
    import vram_blitter_pkg::*;
(
    input  state_e         state,
    input  logic [7:0]     step,
    input  logic [15:0]    src,
    input  logic [15:0]    dst,
    input  logic [7:0]     wr_data,
    output logic [7:0]     rd_data,
    vram_blitter_if.master bus
);

    always_comb begin
        bus.m_ad = '0;
        bus.m_do = '0;
        bus.m_rw = 1'b0;
        bus.m_cs = 1'b0;
        case (state)
            S_SET_STEP: begin
                bus.m_cs = 1'b1;
                bus.m_ad = VC_STEP;
                bus.m_do = step;
            end
            S_SET_RH: begin
                bus.m_cs = 1'b1;
                bus.m_ad = VC_SRC_H;
                bus.m_do = src[15:8];
            end
            S_SET_RL: begin
                bus.m_cs = 1'b1;
                bus.m_ad = VC_SRC_L;
                bus.m_do = src[7:0];
            end
            S_RD: begin
                bus.m_cs = 1'b1;
                bus.m_rw = 1'b1;
                bus.m_ad = VC_DATA;
            end
            S_SET_WH: begin
                bus.m_cs = 1'b1;
                bus.m_ad = VC_DST_H;
                bus.m_do = dst[15:8];
            end
            S_SET_WL: begin
                bus.m_cs = 1'b1;
                bus.m_ad = VC_DST_L;
                bus.m_do = dst[7:0];
            end
            S_WR: begin
                bus.m_cs = 1'b1;
                bus.m_ad = VC_DATA;
                bus.m_do = wr_data;
            end
            default: ;
        endcase
    end

    assign rd_data = bus.m_di;

endmodule

// File: rtl/vram_blitter.sv
// CPU-programmed fill/copy blitter driving a video controller's register port.
// The controller auto-advances its read address, so only DST and LEN are tracked here.
module vram_blitter
    import vram_blitter_pkg::*;
#(
    parameter logic [7:0] STEP_RST = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic [3:0] m_ad,
    output logic [7:0] m_do,
    input  logic [7:0] m_di,
    output logic       m_rw,
    output logic       m_cs,
    output logic       irq
);

    state_e      state_q, state_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] src_q, src_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  fillv_q, fillv_d;
    logic [7:0]  step_q, step_d;
    logic        mode_q, mode_d;
    logic        ie_q, ie_d;
    logic        done_q, done_d;
    logic [7:0]  do_q, do_d;
    logic [15:0] dst_w_q, dst_w_d;
    logic [15:0] len_w_q, len_w_d;
    logic [7:0]  data_q, data_d;

    logic       cpu_wr, cpu_rd, ctrl_wr, busy;
    logic       start_req, abort_req, go;
    logic [7:0] rd_mux, rd_data, wr_data;

    vram_blitter_if mbus ();

    vram_bus_master u_master (
        .state   (state_q),
        .step    (step_q),
        .src     (src_q),
        .dst     (dst_w_q),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .bus     (mbus.master)
    );

    assign m_ad      = mbus.m_ad;
    assign m_do      = mbus.m_do;
    assign m_rw      = mbus.m_rw;
    assign m_cs      = mbus.m_cs;
    assign mbus.m_di = m_di;

    assign busy    = (state_q != S_IDLE);
    assign cpu_wr  = cs & ~rw;
    assign cpu_rd  = cs & rw;
    assign ctrl_wr = cpu_wr && (AD == REG_CTRL);
    // Abort wins over a simultaneous start; a start while busy is dropped.
    assign start_req = ctrl_wr & DI[CTRL_START] & ~DI[CTRL_ABORT] & ~busy;
    assign abort_req = ctrl_wr & DI[CTRL_ABORT] & (busy | DI[CTRL_START]);
    assign go        = start_req & (len_q != 16'h0000);
    assign wr_data   = mode_q ? data_q : fillv_q;
    assign irq       = done_q & ie_q;
    assign DO        = do_q;

    always_comb begin
        rd_mux = '0;
        case (AD)
            REG_CTRL:  rd_mux = ctrl_status(done_q, ie_q, mode_q, busy);
            REG_DST_H: rd_mux = dst_q[15:8];
            REG_DST_L: rd_mux = dst_q[7:0];
            REG_SRC_H: rd_mux = src_q[15:8];
            REG_SRC_L: rd_mux = src_q[7:0];
            REG_LEN_H: rd_mux = len_q[15:8];
            REG_LEN_L: rd_mux = len_q[7:0];
            REG_FILLV: rd_mux = fillv_q;
            REG_STEP:  rd_mux = step_q;
            default:   rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        src_d   = src_q;
        len_d   = len_q;
        fillv_d = fillv_q;
        step_d  = step_q;
        mode_d  = mode_q;
        ie_d    = ie_q;
        done_d  = done_q;
        do_d    = do_q;
        dst_w_d = dst_w_q;
        len_w_d = len_w_q;
        data_d  = data_q;

        if (cpu_rd) begin
            do_d = rd_mux;
        end

        if (cpu_wr && !busy) begin
            case (AD)
                REG_CTRL:  mode_d        = DI[CTRL_MODE];
                REG_DST_H: dst_d[15:8]   = DI;
                REG_DST_L: dst_d[7:0]    = DI;
                REG_SRC_H: src_d[15:8]   = DI;
                REG_SRC_L: src_d[7:0]    = DI;
                REG_LEN_H: len_d[15:8]   = DI;
                REG_LEN_L: len_d[7:0]    = DI;
                REG_FILLV: fillv_d       = DI;
                REG_STEP:  step_d        = DI;
                default: ;
            endcase
        end

        if (ctrl_wr) begin
            ie_d = DI[CTRL_IE];
        end

        if (cpu_rd && (AD == REG_CTRL)) begin
            done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_SET_STEP;
                    dst_w_d = dst_q;
                    len_w_d = len_q;
                    done_d  = 1'b0;
                end else if (start_req) begin
                    done_d = 1'b1;
                end
            end
            S_SET_STEP: state_d = mode_q ? S_SET_RH : S_SET_WH;
            S_SET_RH:   state_d = S_SET_RL;
            S_SET_RL:   state_d = S_RD;
            S_RD:       state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                data_d  = rd_data;
                state_d = S_SET_WH;
            end
            S_SET_WH:   state_d = S_SET_WL;
            S_SET_WL:   state_d = S_WR;
            S_WR: begin
                dst_w_d = dst_w_q + {8'h00, step_q};
                len_w_d = len_w_q - 16'd1;
                if (len_w_q == 16'd1) begin
                    state_d = S_FIN;
                end else begin
                    state_d = mode_q ? S_RD : S_SET_WH;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides the FSM and drops any read result captured this cycle.
        if (abort_req) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            data_d  = data_q;
            dst_w_d = dst_w_q;
            len_w_d = len_w_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            dst_q   <= '0;
            src_q   <= '0;
            len_q   <= '0;
            fillv_q <= '0;
            step_q  <= STEP_RST;
            mode_q  <= 1'b0;
            ie_q    <= 1'b0;
            done_q  <= 1'b0;
            do_q    <= '0;
            dst_w_q <= '0;
            len_w_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            len_q   <= len_d;
            fillv_q <= fillv_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            do_q    <= do_d;
            dst_w_q <= dst_w_d;
            len_w_q <= len_w_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_vram_blitter.sv
// Self-checking bench for vram_blitter: register table, bus-transaction scoreboard
// and directed fill/copy/abort/reset sequences.
module tb_vram_blitter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cpu_ad = '0;
    logic [7:0] cpu_di = '0;
    logic [7:0] cpu_do;
    logic       cpu_rw = 1'b1;
    logic       cpu_cs = 1'b0;
    logic       irq;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cs_count = 0;

    typedef struct {
        logic [3:0] ad;
        logic       rw;
        logic [7:0] d;
    } mtx_t;

    typedef struct {
        logic       do_wr;
        logic [3:0] ad;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    mtx_t       exp_q[$];
    logic [7:0] rd_q[$];
    vec_t       vt[22];

    always #5 clk = ~clk;

    vram_blitter_if vbus ();

    vram_blitter #(.STEP_RST(8'h01)) dut (
        .clk  (clk),
        .rst  (rst),
        .AD   (cpu_ad),
        .DI   (cpu_di),
        .DO   (cpu_do),
        .rw   (cpu_rw),
        .cs   (cpu_cs),
        .m_ad (vbus.m_ad),
        .m_do (vbus.m_do),
        .m_di (vbus.m_di),
        .m_rw (vbus.m_rw),
        .m_cs (vbus.m_cs),
        .irq  (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Video controller: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rst && vbus.m_cs && vbus.m_rw) begin
            if (rd_q.size() > 0) vbus.m_di <= rd_q.pop_front();
            else                 vbus.m_di <= 8'h00;
        end
    end

    always @(negedge clk) begin
        mtx_t e;
        if (rst) begin
            if (vbus.m_cs) begin
                cs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got ad=%h rw=%b do=%h, required no access",
                             vbus.m_ad, vbus.m_rw, vbus.m_do);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_tx", {19'd0, vbus.m_ad, vbus.m_rw, vbus.m_do},
                          {19'd0, e.ad, e.rw, e.d});
                end
            end else begin
                check("bus_idle_zero", {19'd0, vbus.m_ad, vbus.m_rw, vbus.m_do}, 32'd0);
            end
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_ad = a; cpu_di = d;
        @(posedge clk); #1;
        cpu_cs = 1'b0; cpu_rw = 1'b1;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
        cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_ad = a;
        @(posedge clk); #1;
        d = cpu_do;
        cpu_cs = 1'b0;
    endtask

    task automatic set_regs(input logic [15:0] dst, input logic [15:0] src, input logic [15:0] len,
                            input logic [7:0] fillv, input logic [7:0] step);
        cpu_write(4'd1, dst[15:8]); cpu_write(4'd2, dst[7:0]);
        cpu_write(4'd3, src[15:8]); cpu_write(4'd4, src[7:0]);
        cpu_write(4'd5, len[15:8]); cpu_write(4'd6, len[7:0]);
        cpu_write(4'd7, fillv);     cpu_write(4'd8, step);
    endtask

    task automatic push_w(input logic [3:0] a, input logic [7:0] d);
        exp_q.push_back('{a, 1'b0, d});
    endtask

    task automatic push_r();
        exp_q.push_back('{4'hF, 1'b1, 8'h00});
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {8'd0, cpu_do, vbus.m_ad, vbus.m_do, vbus.m_rw, vbus.m_cs, irq, 1'b0},
              32'd0);
    endtask

    initial begin
        logic [7:0]  r;
        int unsigned c0;

        vt[0]  = '{1'b0, 4'd0,  8'h00, 8'h00};
        vt[1]  = '{1'b0, 4'd1,  8'h00, 8'h00};
        vt[2]  = '{1'b0, 4'd2,  8'h00, 8'h00};
        vt[3]  = '{1'b0, 4'd3,  8'h00, 8'h00};
        vt[4]  = '{1'b0, 4'd4,  8'h00, 8'h00};
        vt[5]  = '{1'b0, 4'd5,  8'h00, 8'h00};
        vt[6]  = '{1'b0, 4'd6,  8'h00, 8'h00};
        vt[7]  = '{1'b0, 4'd7,  8'h00, 8'h00};
        vt[8]  = '{1'b0, 4'd8,  8'h00, 8'h01};
        vt[9]  = '{1'b0, 4'd9,  8'h00, 8'h00};
        vt[10] = '{1'b1, 4'd1,  8'h12, 8'h12};
        vt[11] = '{1'b1, 4'd2,  8'h34, 8'h34};
        vt[12] = '{1'b1, 4'd3,  8'h56, 8'h56};
        vt[13] = '{1'b1, 4'd4,  8'h78, 8'h78};
        vt[14] = '{1'b1, 4'd5,  8'h9A, 8'h9A};
        vt[15] = '{1'b1, 4'd6,  8'hBC, 8'hBC};
        vt[16] = '{1'b1, 4'd7,  8'hDE, 8'hDE};
        vt[17] = '{1'b1, 4'd8,  8'hF0, 8'hF0};
        vt[18] = '{1'b1, 4'd9,  8'hFF, 8'h00};
        vt[19] = '{1'b1, 4'd15, 8'hFF, 8'h00};
        vt[20] = '{1'b1, 4'd0,  8'h08, 8'h08};
        vt[21] = '{1'b1, 4'd0,  8'h00, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        rst = 1'b1;
        @(posedge clk); #1;

        for (int unsigned i = 0; i < 22; i++) begin
            if (vt[i].do_wr) cpu_write(vt[i].ad, vt[i].wd);
            cpu_read(vt[i].ad, r);
            check($sformatf("reg_vec_%0d", i), {24'd0, r}, {24'd0, vt[i].exp});
        end

        // Fill: 1 setup + 3x3 per element + FIN = 11 cycles.
        set_regs(16'h0100, 16'h0000, 16'h0003, 8'hAA, 8'h01);
        push_w(4'hE, 8'h01);
        for (int unsigned i = 0; i < 3; i++) begin
            push_w(4'hA, 8'h01); push_w(4'hB, 8'(i)); push_w(4'hF, 8'hAA);
        end
        cpu_write(4'd0, 8'h01);
        repeat (10) @(posedge clk);
        #1;
        cpu_read(4'd0, r);  check("fill_busy_at_fin", {24'd0, r}, 32'h01);
        cpu_read(4'd0, r);  check("fill_done", {24'd0, r}, 32'h80);
        check("fill_all_tx", exp_q.size(), 32'd0);

        // Copy: 3 setup + 5 per element + FIN = 14 cycles.
        set_regs(16'h0300, 16'h0200, 16'h0002, 8'h00, 8'h02);
        rd_q.push_back(8'h11); rd_q.push_back(8'h22);
        push_w(4'hE, 8'h02); push_w(4'hC, 8'h02); push_w(4'hD, 8'h00);
        push_r(); push_w(4'hA, 8'h03); push_w(4'hB, 8'h00); push_w(4'hF, 8'h11);
        push_r(); push_w(4'hA, 8'h03); push_w(4'hB, 8'h02); push_w(4'hF, 8'h22);
        cpu_write(4'd0, 8'h03);
        repeat (13) @(posedge clk);
        #1;
        cpu_read(4'd0, r);  check("copy_busy_at_fin", {24'd0, r}, 32'h05);
        cpu_read(4'd0, r);  check("copy_done", {24'd0, r}, 32'h84);
        check("copy_all_tx", exp_q.size(), 32'd0);

        // LEN=0: done immediately, no bus access; CTRL read clears done.
        set_regs(16'h0100, 16'h0000, 16'h0000, 8'hAA, 8'h01);
        c0 = cs_count;
        cpu_write(4'd0, 8'h01);
        cpu_read(4'd0, r);  check("len0_done", {24'd0, r}, 32'h80);
        cpu_read(4'd0, r);  check("len0_done_cleared", {24'd0, r}, 32'h00);
        repeat (3) @(posedge clk);
        #1;
        check("len0_no_bus", cs_count - c0, 32'd0);

        // DST wraps FFFF -> 0000.
        set_regs(16'hFFFF, 16'h0000, 16'h0002, 8'h5A, 8'h01);
        push_w(4'hE, 8'h01);
        push_w(4'hA, 8'hFF); push_w(4'hB, 8'hFF); push_w(4'hF, 8'h5A);
        push_w(4'hA, 8'h00); push_w(4'hB, 8'h00); push_w(4'hF, 8'h5A);
        cpu_write(4'd0, 8'h01);
        repeat (7) @(posedge clk);
        #1;
        cpu_read(4'd0, r);  check("wrap_busy_at_fin", {24'd0, r}, 32'h01);
        cpu_read(4'd0, r);  check("wrap_done", {24'd0, r}, 32'h80);
        check("wrap_all_tx", exp_q.size(), 32'd0);

        // Abort during element 2; busy writes and a busy start are ignored.
        set_regs(16'h0010, 16'h0000, 16'h0005, 8'h55, 8'h01);
        push_w(4'hE, 8'h01);
        push_w(4'hA, 8'h00); push_w(4'hB, 8'h10); push_w(4'hF, 8'h55);
        push_w(4'hA, 8'h00);
        cpu_write(4'd0, 8'h09);
        cpu_write(4'd7, 8'h77);
        cpu_write(4'd0, 8'h09);
        check("abort_irq_while_busy", {31'd0, irq}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_bus_active_before", {31'd0, vbus.m_cs}, 32'd1);
        cpu_write(4'd0, 8'h0C);
        check("abort_m_cs_low", {31'd0, vbus.m_cs}, 32'd0);
        check("abort_irq", {31'd0, irq}, 32'd1);
        cpu_read(4'd0, r);  check("abort_ctrl", {24'd0, r}, 32'h88);
        check("abort_irq_cleared", {31'd0, irq}, 32'd0);
        cpu_read(4'd7, r);  check("abort_fillv_kept", {24'd0, r}, 32'h55);
        check("abort_all_tx", exp_q.size(), 32'd0);

        // Reset in the middle of a copy.
        set_regs(16'h0300, 16'h0200, 16'h0003, 8'h00, 8'h02);
        cpu_read(4'd8, r);  check("step_before_rst", {24'd0, r}, 32'h02);
        cpu_write(4'd7, 8'h00);
        check("do_holds", {24'd0, cpu_do}, 32'h02);
        rd_q.push_back(8'h33); rd_q.push_back(8'h44); rd_q.push_back(8'h55);
        push_w(4'hE, 8'h02); push_w(4'hC, 8'h02); push_w(4'hD, 8'h00);
        push_r(); push_w(4'hA, 8'h03);
        cpu_write(4'd0, 8'h03);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_outputs_zero("rst_mid_outputs");
        check("rst_mid_tx_seen", exp_q.size(), 32'd0);
        exp_q.delete();
        rd_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("rst_hold_outputs");
        rst = 1'b1;
        c0 = cs_count;
        repeat (20) @(posedge clk);
        #1;
        check("rst_no_bus_after", cs_count - c0, 32'd0);
        cpu_read(4'd8, r);  check("rst_step", {24'd0, r}, 32'h01);
        cpu_read(4'd1, r);  check("rst_dst_h", {24'd0, r}, 32'h00);
        cpu_read(4'd0, r);  check("rst_ctrl", {24'd0, r}, 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_blitter.md
VRAM_BLITTER -- requirements
Module: vram_blitter

Interface
REQ-001 The block SHALL have these ports, with clock and reset first:
  clk  in  1  system clock; all logic on its rising edge
  rst  in  1  reset; asynchronous assertion, active-low
  AD  in  4  CPU register address
  DI  in  8  CPU write data
  DO  out  8  CPU read data, registered
  rw  in  1  CPU direction: 1 = read, 0 = write
  cs  in  1  CPU select; one access per cycle while high
  m_ad  out  4  master address to the video controller register port
  m_do  out  8  master write data
  m_di  in  8  master read data, valid the cycle after a read strobe
  m_rw  out  1  master direction: 1 = read
  m_cs  out  1  master strobe, one cycle per access
  irq  out  1  completion interrupt, level
REQ-002 The block SHALL have one parameter: STEP_RST, default 8'h01, the reset value of the STEP register.

Function
REQ-003 CPU register map SHALL be: 0 CTRL, 1 DST_H, 2 DST_L, 3 SRC_H, 4 SRC_L, 5 LEN_H, 6 LEN_L, 7 FILLV, 8 STEP. Other addresses SHALL read 8'h00 and ignore writes.
REQ-004 CTRL write bits SHALL be: bit0 start, bit1 mode (0 = fill, 1 = copy), bit2 abort, bit3 irq enable.
REQ-005 CTRL read SHALL return {done, 3'b0, ie, mode, 1'b0, busy}.
REQ-006 DO SHALL update on the clock edge where cs=1 and rw=1, and SHALL hold its value otherwise.
REQ-007 While busy=1, writes to addresses 1-8 SHALL be ignored.
REQ-008 While busy=1, a CTRL write SHALL act only on bit2 (abort) and bit3 (ie).
REQ-009 Start with LEN=0 SHALL set done=1 without any master cycle.
REQ-010 Start with LEN≠0 SHALL set busy=1 and clear done. Working copies of DST, SRC and LEN SHALL be latched so the CPU registers keep their values.
REQ-011 FSM states SHALL be IDLE, SET_STEP, SET_RH, SET_RL, RD, RD_WAIT, SET_WH, SET_WL, WR, FIN.
REQ-012 State behaviour:
  SET_STEP: master write AD=E, data STEP
  SET_RH / SET_RL: master write AD=C / D, data SRC high / low byte (copy mode only)
  RD: master read AD=F
  RD_WAIT: m_cs=0; capture m_di into the data latch
  SET_WH / SET_WL: master write AD=A / B, data working DST high / low byte
  WR: master write AD=F, data = FILLV (fill) or the data latch (copy)
REQ-013 Transitions:
  IDLE -> SET_STEP on start
  SET_STEP -> SET_RH (copy) or SET_WH (fill)
  SET_RL -> RD; RD_WAIT -> SET_WH
  After WR: DST += STEP (mod 2^16), LEN -= 1; if the new LEN is 0 go to FIN, else go to RD (copy) or SET_WH (fill)
  FIN: done=1, busy=0, go to IDLE
REQ-014 Per-element cost SHALL be 3 cycles in fill mode and 5 in copy mode. Setup cost SHALL be 1 cycle (fill) or 3 cycles (copy). FIN SHALL take 1 cycle.
REQ-015 The source address SHALL not be tracked internally. Source advance relies on the video controller auto-incrementing its read address by STEP on each AD=F read.
REQ-016 DST and LEN arithmetic SHALL be 16-bit unsigned. DST wraps FFFF -> 0000 silently.
REQ-017 Abort SHALL force IDLE on the next edge with m_cs=0 that cycle, busy=0, done=1. An in-flight read result SHALL be discarded.
REQ-018 Start and abort set in the same CTRL write SHALL resolve as abort, with no transfer begun.
REQ-019 Start while busy SHALL be ignored.
REQ-020 m_cs SHALL be 1 only in SET_*, RD and WR states. When m_cs=0, m_ad, m_do and m_rw SHALL hold 0.
REQ-021 irq SHALL equal done & ie.
REQ-022 done SHALL clear on a CTRL read or on the next accepted start.

Reset
REQ-023 While rst=0, all outputs SHALL be 0 and the FSM SHALL be in IDLE.
REQ-024 While rst=0, every register SHALL be 0 except STEP=STEP_RST. done, busy and ie SHALL be 0.
REQ-025 A reset during a transfer SHALL terminate it immediately with no further master cycles.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, the CPU register addresses (0-8), the video-controller port addresses (A, B, C, D, E, F) and the CTRL bit positions.
REQ-027 No sub-module is required. The master-port driver MAY be factored out as vram_bus_master.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
  - Fill: DST=0100, LEN=0003, STEP=01, FILLV=AA, CTRL=01 -> master writes E/01, then (A/01, B/00, F/AA), (A/01, B/01, F/AA), (A/01, B/02, F/AA); done after 11 cycles.
  - Copy: SRC=0200, DST=0300, LEN=0002, STEP=02, CTRL=03, model returns 11 then 22 -> writes F/11 at 0300, F/22 at 0302; reads issued at AD=F twice.
  - LEN=0, CTRL=01 -> no m_cs pulse; CTRL reads 8'h80 next access.
  - Wrap: DST=FFFF, LEN=2, STEP=01 fill -> second element written at 0000.
  - Abort: CTRL=04 during element 2 of LEN=5 fill -> m_cs low next cycle, busy=0, done=1; irq=1 if ie was set.
  - rst low mid-copy -> all outputs 0, STEP=01, no master cycles after release.
